// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory controller slice.
//   memState_t      : controller FSM state encoding (IDLE / BUSY)
//   DEFAULT_DEPTH   : default number of 32-bit words in the data RAM
//   DEFAULT_LATENCY : default number of wait cycles per memory access
//   ADDR_IDX_W      : word-index width for the default depth
//   idxWidth()      : word-index width for an arbitrary depth
package data_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } memState_t;

  localparam int DEFAULT_DEPTH   = 256;
  localparam int DEFAULT_LATENCY = 2;
  localparam int ADDR_IDX_W      = $clog2(DEFAULT_DEPTH);

  // A one-word memory still needs a one-bit index to keep port widths legal.
  function automatic int idxWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port data RAM, DEPTH x 32, synchronous write, asynchronous read.
// Contents are not reset.
//   clk       : clock
//   writeEn   : write strobe, word written at the rising edge
//   addr      : word index shared by read and write
//   writeData : word to store
//   readData  : word at addr (combinational)
module data_ram #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             writeEn,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      writeData,
  output logic [31:0]      readData
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (writeEn) begin
      mem[addr] <= writeData;
    end
  end

  assign readData = mem[addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM stage of the pipeline: data memory access with a programmable number of
// wait cycles, followed by the MEM/WB pipeline register.
//   clk, reset      : clock, synchronous active-high reset
//   MemReadM        : load request
//   MemWriteM       : store request
//   MemtoRegM       : writeback selects memory data
//   RegWriteM       : instruction writes the register file
//   ALUResultAddrM  : byte address / ALU result
//   DataWriteInM    : store data
//   RegisterDstM    : destination register
//   Stall           : combinational hold request to upstream stages
//   RegWriteW, MemtoRegW, ReadDataW, ALUResultW, RegisterDstW : MEM/WB register
//   MemFault        : one-cycle pulse for a rejected access
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int DEPTH   = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic        RegWriteM,
  input  logic [31:0] ALUResultAddrM,
  input  logic [31:0] DataWriteInM,
  input  logic [4:0]  RegisterDstM,
  output logic        Stall,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [4:0]  RegisterDstW,
  output logic        MemFault
);

  localparam int IDX_W = idxWidth(DEPTH);

  memState_t   state, stateNext;
  logic [3:0]  waitCnt, waitCntNext;
  logic        complete;

  logic        isMemOp;
  logic        validAccess;
  logic        invalidAccess;
  logic        ramWriteEn;
  logic [31:0] ramReadData;

  // Access decode: exactly one of read/write, word aligned, inside the RAM.
  assign isMemOp       = MemReadM | MemWriteM;
  assign validAccess   = (MemReadM ^ MemWriteM) &&
                         (ALUResultAddrM[1:0] == 2'b00) &&
                         ({2'b00, ALUResultAddrM[31:2]} < 32'(DEPTH));
  assign invalidAccess = isMemOp & ~validAccess;

  // The write happens only on the completing edge; a reset on that edge
  // aborts the access.
  assign ramWriteEn = complete & validAccess & MemWriteM & ~reset;

  data_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk       (clk),
    .writeEn   (ramWriteEn),
    .addr      (ALUResultAddrM[IDX_W+1:2]),
    .writeData (DataWriteInM),
    .readData  (ramReadData)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      waitCnt <= 4'd0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  // Every cycle either stalls or completes the instruction currently held in
  // the M inputs; non-memory and rejected accesses always complete at once.
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    Stall       = 1'b0;
    complete    = 1'b0;
    unique case (state)
      IDLE: begin
        if (validAccess && (LATENCY > 0)) begin
          stateNext   = BUSY;
          waitCntNext = 4'(LATENCY - 1);
          Stall       = 1'b1;
        end else begin
          complete = 1'b1;
        end
      end
      BUSY: begin
        if (waitCnt != 4'd0) begin
          waitCntNext = waitCnt - 4'd1;
          Stall       = 1'b1;
        end else begin
          stateNext = IDLE;
          complete  = 1'b1;
        end
      end
      default: begin
        stateNext   = IDLE;
        waitCntNext = 4'd0;
      end
    endcase
  end

  // MEM/WB register: bubble while stalled, result on completion. A rejected
  // access kills its writeback entirely and raises MemFault.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteW    <= 1'b0;
      MemtoRegW    <= 1'b0;
      ReadDataW    <= 32'd0;
      ALUResultW   <= 32'd0;
      RegisterDstW <= 5'd0;
      MemFault     <= 1'b0;
    end else if (Stall) begin
      RegWriteW    <= 1'b0;
      MemtoRegW    <= 1'b0;
      ReadDataW    <= 32'd0;
      ALUResultW   <= 32'd0;
      RegisterDstW <= 5'd0;
      MemFault     <= 1'b0;
    end else begin
      RegWriteW    <= RegWriteM & ~invalidAccess;
      MemtoRegW    <= MemtoRegM & ~invalidAccess;
      ReadDataW    <= (validAccess && MemReadM) ? ramReadData : 32'd0;
      ALUResultW   <= ALUResultAddrM;
      RegisterDstW <= RegisterDstM;
      MemFault     <= invalidAccess;
    end
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 2, number of wait cycles per memory access (legal 0..15).
REQ-002 SHALL have parameter DEPTH, default 256, number of 32-bit words of data memory.
REQ-003 SHALL have ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have the following EX/MEM-side input ports:
- MemReadM  in  1  load request.
- MemWriteM  in  1  store request.
- MemtoRegM  in  1  WB selects memory data.
- RegWriteM  in  1  instruction writes register file.
- ALUResultAddrM  in  32  byte address / ALU result.
- DataWriteInM  in  32  store data.
- RegisterDstM  in  5  destination register.
REQ-005 SHALL have ports:
- Stall  out  1  upstream hold request, combinational.
- RegWriteW  out  1  registered MEM/WB control.
- MemtoRegW  out  1  registered MEM/WB control.
- ReadDataW  out  32  load result.
- ALUResultW  out  32  passed-through ALU result.
- RegisterDstW  out  5  passed-through destination register.
- MemFault  out  1  one-cycle registered fault pulse.

Function
REQ-006 SHALL decode valid access as: exactly one of MemReadM/MemWriteM high, ALUResultAddrM[1:0]==0, word index ALUResultAddrM[31:2] < DEPTH.
REQ-007 SHALL implement FSM states IDLE and BUSY with a 4-bit wait counter.
REQ-008 IDLE transitions:
- valid access with LATENCY>0: go to BUSY, counter=LATENCY-1.
- otherwise: stay in IDLE.
REQ-009 BUSY transitions:
- counter>0: decrement.
- counter==0: perform access at the clock edge, return to IDLE.
REQ-010 Stall SHALL be 1 when (IDLE and valid access and LATENCY>0) or (BUSY and counter>0), else 0.
- Stall is high for exactly LATENCY cycles per access.
- The MEM/WB registers load the result at the end of cycle LATENCY.
REQ-011 Non-memory instructions (MemReadM=MemWriteM=0) SHALL pass to the W outputs in one cycle with no stall.
- ReadDataW=0 for these.
REQ-012 While Stall=1, the W outputs SHALL load a bubble: RegWriteW=0, MemtoRegW=0, data fields 0.
REQ-013 A store SHALL write DataWriteInM to word ALUResultAddrM[31:2] on the completing edge only; ReadDataW=0.
REQ-014 A load SHALL return the word at ALUResultAddrM[31:2] on the completing edge.
- A load directly following a store to the same address returns the stored data.
REQ-015 An invalid access (misaligned, out of range, or MemReadM&MemWriteM) SHALL complete in one cycle with no stall and no memory write.
- Pulses MemFault=1 for one cycle.
- Forces RegWriteW=0 and ReadDataW=0.
REQ-016 Inputs SHALL be sampled on the completing edge; upstream holds them stable while Stall=1.
REQ-017 LATENCY=0 SHALL yield single-cycle access; Stall is never asserted.

Reset
REQ-018 On reset=1 at a clock edge:
- FSM returns to IDLE and counter clears.
- All W outputs and MemFault become 0.
- Stall becomes 0 in the following cycle unless a new access is present.
REQ-019 Reset during BUSY SHALL abort the access with no memory write.
REQ-020 Reset SHALL NOT clear RAM contents.

Structure
REQ-021 Shared package data_mem_pkg SHALL hold:
- the FSM state type,
- the DEPTH default,
- the LATENCY default,
- the address index width.
REQ-022 RAM SHALL be a separate sub-module data_ram: single-port, synchronous write, asynchronous read, DEPTH x 32.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Store 0xDEADBEEF to 0x10, LATENCY=2 -> Stall high 2 cycles, bubble in W for those cycles, then RegWriteW=0; later load from 0x10 -> ReadDataW=0xDEADBEEF, MemtoRegW=1.
- ALU op RegWriteM=1, RegisterDstM=5, ALUResultAddrM=0x1234 -> next cycle RegWriteW=1, RegisterDstW=5, ALUResultW=0x1234, Stall never high.
- Load from 0x13 (misaligned) and from 0x400 (out of range, DEPTH=256) -> MemFault one-cycle pulse each, no Stall, RegWriteW=0, ReadDataW=0.
- Store 0x55 to 0x20 with reset asserted in the BUSY cycle -> state IDLE, outputs 0, load from 0x20 returns prior contents (not 0x55).
- Back-to-back store 0xA5A5A5A5 to 0x8 then load from 0x8 with LATENCY=0 -> no Stall, load returns 0xA5A5A5A5 one cycle after issue.
- MemReadM=MemWriteM=1 at 0x4 -> MemFault=1, memory word 0x4 unchanged.
